// File: rtl/expr_eval.sv
// rtl/expr_eval.sv - streaming evaluator for digit((+|*)digit)* ASCII expressions
// Keeps a running sum of completed terms plus the term under construction.
module expr_eval #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         in_valid,
   input  logic [7:0]   in,
   output logic         ok,
   output logic         err,
   output logic [W-1:0] result,
   output logic         ovf
);

   typedef enum logic [1:0] {INIT, NUM, OP, ERR} state_t;

   state_t       state, state_nxt;
   logic [W-1:0] sum, sum_nxt;
   logic [W-1:0] term, term_nxt;
   logic         mul_pend, mul_pend_nxt;
   logic         ovf_nxt;

   logic         is_digit;
   logic         is_op;
   logic [3:0]   d;
   logic [W+3:0] prod;
   logic [W:0]   add;

   assign is_digit = (in >= 8'h30) && (in <= 8'h39);
   assign is_op    = (in == 8'h2b) || (in == 8'h2a);
   // ASCII '0'..'9' are 0x30..0x39, so the low nibble is the digit value
   assign d        = in[3:0];
   assign prod     = {4'b0, term} * {{W{1'b0}}, d};
   assign add      = {1'b0, sum} + {1'b0, term};

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state    <= INIT;
         sum      <= '0;
         term     <= '0;
         mul_pend <= 1'b0;
         ovf      <= 1'b0;
      end else if (in_valid) begin
         state    <= state_nxt;
         sum      <= sum_nxt;
         term     <= term_nxt;
         mul_pend <= mul_pend_nxt;
         ovf      <= ovf_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      sum_nxt      = sum;
      term_nxt     = term;
      mul_pend_nxt = mul_pend;
      ovf_nxt      = ovf;
      case (state)
         INIT: begin
            if (is_digit) begin
               state_nxt = NUM;
               sum_nxt   = '0;
               term_nxt  = W'(d);
            end else begin
               state_nxt = ERR;
            end
         end
         NUM: begin
            if (is_op) begin
               state_nxt    = OP;
               mul_pend_nxt = (in == 8'h2a);
            end else begin
               state_nxt = ERR;
            end
         end
         OP: begin
            if (is_digit) begin
               state_nxt = NUM;
               // '*' extends the current term; '+' retires it into the sum
               if (mul_pend) begin
                  term_nxt = prod[W-1:0];
                  ovf_nxt  = ovf | (|prod[W+3:W]);
               end else begin
                  sum_nxt  = add[W-1:0];
                  term_nxt = W'(d);
                  ovf_nxt  = ovf | add[W];
               end
            end else begin
               state_nxt = ERR;
            end
         end
         ERR: ;
         default: state_nxt = ERR;
      endcase
   end

   assign ok     = (state == NUM);
   assign err    = (state == ERR);
   assign result = ok ? (sum + term) : '0;

endmodule

// File: tb/tb_expr_eval.sv
// tb/tb_expr_eval.sv - randomized and directed bench for expr_eval at W=16 and W=8
// The reference re-parses every accepted character since the last clr each cycle.
module tb_expr_eval;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in = 8'h00;
   logic        ok16, err16, ovf16;
   logic [15:0] res16;
   logic        ok8, err8, ovf8;
   logic [7:0]  res8;

   int          tests = 0;
   int          fails = 0;
   logic [7:0]  q[$];

   always #5 clk = ~clk;

   expr_eval #(.W(16)) dut16 (
      .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
      .ok(ok16), .err(err16), .result(res16), .ovf(ovf16)
   );

   expr_eval #(.W(8)) dut8 (
      .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
      .ok(ok8), .err(err8), .result(res8), .ovf(ovf8)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Well-formed prefix: even positions are digits, odd positions are operators.
   function automatic void model(input int w, output bit m_ok, output bit m_err,
                                 output bit m_ovf, output longint m_res);
      longint mask = (longint'(1) << w) - 1;
      longint s = 0;
      longint t = 0;
      longint full;
      longint dv;
      bit     bad = 0;
      m_ovf = 0;
      foreach (q[i]) begin
         if (!bad) begin
            if (i % 2 == 0) begin
               if (q[i] < 8'h30 || q[i] > 8'h39) bad = 1;
               else begin
                  dv = longint'(q[i]) - 48;
                  if (i == 0) begin
                     s = 0;
                     t = dv;
                  end else if (q[i-1] == 8'h2a) begin
                     full = t * dv;
                     if (full > mask) m_ovf = 1;
                     t = full & mask;
                  end else begin
                     full = s + t;
                     if (full > mask) m_ovf = 1;
                     s = full & mask;
                     t = dv;
                  end
               end
            end else if (q[i] != 8'h2b && q[i] != 8'h2a) begin
               bad = 1;
            end
         end
      end
      m_err = bad;
      m_ok  = !bad && (q.size() % 2 == 1);
      m_res = m_ok ? ((s + t) & mask) : 0;
   endfunction

   always @(posedge clk) begin
      bit     e_ok, e_err, e_ovf;
      longint e_res;
      if (clr) q.delete();
      else if (in_valid) q.push_back(in);
      #2;
      model(16, e_ok, e_err, e_ovf, e_res);
      chk("m16_ok", ok16, e_ok);
      chk("m16_err", err16, e_err);
      chk("m16_ovf", ovf16, e_ovf);
      chk("m16_result", res16, e_res);
      model(8, e_ok, e_err, e_ovf, e_res);
      chk("m8_ok", ok8, e_ok);
      chk("m8_err", err8, e_err);
      chk("m8_ovf", ovf8, e_ovf);
      chk("m8_result", res8, e_res);
   end

   task automatic send(input logic [7:0] c);
      @(negedge clk);
      in = c;
      in_valid = 1'b1;
      @(posedge clk);
      #3;
      in_valid = 1'b0;
      in = 8'($urandom);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   // Held across a clock edge with a valid digit on in to show clr wins.
   task automatic pulse_clr();
      @(negedge clk);
      clr = 1'b1;
      in_valid = 1'b1;
      in = "5";
      @(negedge clk);
      clr = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic gap3();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         in = 8'($urandom);
         @(posedge clk);
         #3;
      end
   endtask

   initial begin
      int    e_ok1[5]  = '{1, 0, 1, 0, 1};
      int    e_res1[5] = '{1, 0, 3, 0, 7};
      string s1 = "1+2*3";
      int    n;
      int    len;
      int    r;

      pulse_clr();
      chk("rst_ok", ok16, 0);
      chk("rst_err", err16, 0);
      chk("rst_result", res16, 0);
      chk("rst_ovf", ovf16, 0);

      for (int i = 0; i < 5; i++) begin
         send(s1[i]);
         chk("seq1_ok", ok16, e_ok1[i]);
         chk("seq1_result", res16, e_res1[i]);
         chk("seq1_err", err16, 0);
      end

      pulse_clr();
      send_str("2*3*4+");
      chk("plus_ok", ok16, 0);
      chk("plus_result", res16, 0);
      send("5");
      chk("seq2_ok", ok16, 1);
      chk("seq2_result", res16, 29);

      pulse_clr();
      send("+");
      chk("lead_op_err", err16, 1);
      chk("lead_op_ok", ok16, 0);
      send("5");
      chk("err_sticky", err16, 1);
      clr = 1'b1;
      #1;
      chk("async_clr_err", err16, 0);
      q.delete();
      #1;
      clr = 1'b0;

      pulse_clr();
      send_str("12");
      chk("two_digit_err", err16, 1);
      pulse_clr();
      send_str("7a");
      chk("other_err", err16, 1);
      pulse_clr();
      send_str("7++");
      chk("double_op_err", err16, 1);

      pulse_clr();
      send_str("9*9*9");
      chk("w8_result", res8, 217);
      chk("w8_ovf", ovf8, 1);
      chk("w8_ok", ok8, 1);
      chk("w16_result", res16, 729);
      chk("w16_ovf", ovf16, 0);
      pulse_clr();
      chk("w8_ovf_clr", ovf8, 0);

      pulse_clr();
      send("3");
      gap3();
      chk("gap_result_a", res16, 3);
      send("+");
      gap3();
      chk("gap_ok_b", ok16, 0);
      send("4");
      gap3();
      chk("gap_result", res16, 7);
      chk("gap_ok", ok16, 1);

      pulse_clr();
      n = 0;
      len = $urandom_range(1, 25);
      repeat (3000) begin
         @(negedge clk);
         if (n >= len || $urandom_range(0, 99) == 0) begin
            clr = 1'b1;
            in_valid = 1'($urandom);
            in = 8'($urandom);
            n = 0;
            len = $urandom_range(1, 25);
         end else begin
            clr = 1'b0;
            in_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 99);
            if (r < 3) in = 8'($urandom);
            else if (n % 2 == 0) in = (r < 50) ? 8'h39 : 8'(8'h30 + $urandom_range(0, 9));
            else in = (r < 55) ? 8'h2a : 8'h2b;
            if (in_valid) n++;
         end
      end
      @(negedge clk);
      clr = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #3;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
